// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner of the shared 4:1 single-bit mux: grants one requester, drives sel, registers x[sel].
// Optional hold timeout enabled by defining MUX4_ARB_TIMEOUT_EN (limit set by HOLD_MAX).
module mux4_rr_arbiter #(
  parameter int HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] x,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       busy,
  output logic       y,
  output logic       y_valid
);

  if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold_max
    $error("HOLD_MAX must be in 2..255");
  end

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state_p0, state_nxt;
  logic [1:0] ptr_p0, ptr_nxt;
  logic [1:0] sel_p0, sel_nxt;
  logic [3:0] others;
  logic       y_p1, vld_p1;

  // First set bit of mask searching start, start+1, ... modulo 4.
  function automatic logic [1:0] first_from(input logic [3:0] mask, input logic [1:0] start);
    logic [1:0] idx;
    logic [1:0] cand;
    logic       found;
    idx   = start;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cand = start + 2'(i);
      if (!found && mask[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
    return idx;
  endfunction

`ifdef MUX4_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  logic [7:0] hold_p0, hold_nxt;

  function automatic logic [7:0] sat_inc(input logic [7:0] h);
    return (h >= HOLD_LAST) ? HOLD_LAST : h + 8'd1;
  endfunction
`endif

  assign others = req & ~(4'b0001 << sel_p0);

  always_comb begin
    state_nxt = state_p0;
    ptr_nxt   = ptr_p0;
    sel_nxt   = sel_p0;
`ifdef MUX4_ARB_TIMEOUT_EN
    hold_nxt  = hold_p0;
`endif
    unique case (state_p0)
      IDLE: begin
        if (|req) begin
          state_nxt = GRANT;
          sel_nxt   = first_from(req, ptr_p0);
          ptr_nxt   = sel_nxt + 2'd1;
`ifdef MUX4_ARB_TIMEOUT_EN
          hold_nxt  = 8'd0;
`endif
        end
      end
      GRANT: begin
        if (!req[sel_p0]) begin
          if (|others) begin
            sel_nxt = first_from(others, sel_p0 + 2'd1);
            ptr_nxt = sel_nxt + 2'd1;
          end else begin
            state_nxt = IDLE;
            sel_nxt   = 2'd0;
          end
`ifdef MUX4_ARB_TIMEOUT_EN
          hold_nxt = 8'd0;
        end else if (hold_p0 == HOLD_LAST && |others) begin
          // Owner has used its full slot and someone is waiting: rotate.
          sel_nxt  = first_from(others, sel_p0 + 2'd1);
          ptr_nxt  = sel_nxt + 2'd1;
          hold_nxt = 8'd0;
        end else begin
          hold_nxt = sat_inc(hold_p0);
`endif
        end
      end
      default: begin
        state_nxt = IDLE;
        sel_nxt   = 2'd0;
      end
    endcase
  end

  // Stage p0: arbitration state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0 <= IDLE;
      ptr_p0   <= 2'd0;
      sel_p0   <= 2'd0;
`ifdef MUX4_ARB_TIMEOUT_EN
      hold_p0  <= 8'd0;
`endif
    end else begin
      state_p0 <= state_nxt;
      ptr_p0   <= ptr_nxt;
      sel_p0   <= sel_nxt;
`ifdef MUX4_ARB_TIMEOUT_EN
      hold_p0  <= hold_nxt;
`endif
    end
  end

  assign busy  = (state_p0 == GRANT);
  assign grant = busy ? (4'b0001 << sel_p0) : 4'b0000;
  assign sel   = sel_p0;

  // Stage p1: registered mux output
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      y_p1   <= 1'b0;
    end else begin
      vld_p1 <= busy;
      y_p1   <= busy ? x[sel_p0] : 1'b0;
    end
  end

  assign y       = y_p1;
  assign y_valid = vld_p1;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench for mux4_rr_arbiter: directed req/x vectors with hand-computed grants.
module tb_mux4_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] x   = 4'b0000;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       busy;
  logic       y;
  logic       y_valid;

  mux4_rr_arbiter #(.HOLD_MAX(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .x       (x),
    .grant   (grant),
    .sel     (sel),
    .busy    (busy),
    .y       (y),
    .y_valid (y_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy;
    logic       y;
    logic       yv;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] cur_grant = 4'b0000;
  int         checks = 0;
  int         errors = 0;

  function automatic logic [1:0] idx(input logic [3:0] g);
    case (g)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // Drive one cycle of inputs and queue what the DUT must show after the next edge.
  task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] xv, input logic [3:0] eg);
    exp_t e;
    @(negedge clk);
    rst = r;
    req = rq;
    x   = xv;
    if (r) begin
      e.yv = 1'b0;
      e.y  = 1'b0;
    end else begin
      e.yv = |cur_grant;
      e.y  = (|cur_grant) ? xv[idx(cur_grant)] : 1'b0;
    end
    e.grant = eg;
    e.sel   = idx(eg);
    e.busy  = |eg;
    sb.push_back(e);
    cur_grant = r ? 4'b0000 : eg;
  endtask

  // Monitor: compare DUT outputs just after every edge for which an expectation exists.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (grant !== e.grant) begin
          errors++;
          $display("FAIL grant at %0t: got %b want %b", $time, grant, e.grant);
        end
        checks++;
        if (sel !== e.sel) begin
          errors++;
          $display("FAIL sel at %0t: got %0d want %0d", $time, sel, e.sel);
        end
        checks++;
        if (busy !== e.busy) begin
          errors++;
          $display("FAIL busy at %0t: got %b want %b", $time, busy, e.busy);
        end
        checks++;
        if (y_valid !== e.yv) begin
          errors++;
          $display("FAIL y_valid at %0t: got %b want %b", $time, y_valid, e.yv);
        end
        checks++;
        if (y !== e.y) begin
          errors++;
          $display("FAIL y at %0t: got %b want %b", $time, y, e.y);
        end
      end
    end
  end

  initial begin
    // Reset held with all requests pending, then first grant from ptr=0.
    step(1'b1, 4'b1111, 4'b1111, 4'b0000);
    step(1'b1, 4'b1111, 4'b1111, 4'b0000);
    step(1'b0, 4'b1111, 4'b1010, 4'b0001);

    // Round robin: each owner keeps 3 cycles then drops for one.
    step(1'b0, 4'b1111, 4'b1010, 4'b0001);
    step(1'b0, 4'b1111, 4'b1010, 4'b0001);
    step(1'b0, 4'b1110, 4'b1010, 4'b0010);
    step(1'b0, 4'b1111, 4'b1010, 4'b0010);
    step(1'b0, 4'b1111, 4'b1010, 4'b0010);
    step(1'b0, 4'b1101, 4'b1010, 4'b0100);
    step(1'b0, 4'b1111, 4'b1010, 4'b0100);
    step(1'b0, 4'b1111, 4'b1010, 4'b0100);
    step(1'b0, 4'b1011, 4'b1010, 4'b1000);
    step(1'b0, 4'b1111, 4'b1010, 4'b1000);
    step(1'b0, 4'b1111, 4'b1010, 4'b1000);
    step(1'b0, 4'b0111, 4'b1010, 4'b0001);

    // Data path through owner 2; other x bits toggle against it.
    step(1'b0, 4'b0100, 4'b0000, 4'b0100);
    step(1'b0, 4'b0100, 4'b0100, 4'b0100);
    step(1'b0, 4'b0100, 4'b1011, 4'b0100);
    step(1'b0, 4'b0100, 4'b1101, 4'b0100);

    // Release to idle; idle y stays 0 even with x all ones.
    step(1'b0, 4'b0000, 4'b1111, 4'b0000);
    step(1'b0, 4'b0000, 4'b1111, 4'b0000);

    // Four-cycle req[3] pulse.
    step(1'b0, 4'b1000, 4'b1000, 4'b1000);
    step(1'b0, 4'b1000, 4'b0000, 4'b1000);
    step(1'b0, 4'b1000, 4'b1000, 4'b1000);
    step(1'b0, 4'b1000, 4'b0111, 4'b1000);
    step(1'b0, 4'b0000, 4'b1000, 4'b0000);
    step(1'b0, 4'b0000, 4'b1111, 4'b0000);

    // Simultaneous requests resolved by ptr (ptr=0 after owner 3).
    step(1'b0, 4'b0110, 4'b0010, 4'b0010);
    step(1'b0, 4'b0100, 4'b0000, 4'b0100);
    step(1'b0, 4'b0000, 4'b0100, 4'b0000);

    // Reset mid-grant drops the grant and restores ptr=0.
    step(1'b0, 4'b0001, 4'b0001, 4'b0001);
    step(1'b1, 4'b0001, 4'b0001, 4'b0000);
    step(1'b0, 4'b0011, 4'b0011, 4'b0001);
    step(1'b0, 4'b0000, 4'b0001, 4'b0000);

    // Owner 0 holding while requester 1 waits.
    step(1'b0, 4'b0001, 4'b0001, 4'b0001);
    step(1'b0, 4'b0011, 4'b0001, 4'b0001);
    step(1'b0, 4'b0011, 4'b0000, 4'b0001);
    step(1'b0, 4'b0011, 4'b0001, 4'b0001);
`ifdef MUX4_ARB_TIMEOUT_EN
    step(1'b0, 4'b0011, 4'b0010, 4'b0010);
    step(1'b0, 4'b0001, 4'b0010, 4'b0001);
    for (int i = 0; i < 7; i++) step(1'b0, 4'b0001, 4'(i), 4'b0001);
    step(1'b0, 4'b0011, 4'b0001, 4'b0010);
    step(1'b0, 4'b0000, 4'b0010, 4'b0000);
    step(1'b0, 4'b0000, 4'b0000, 4'b0000);
`else
    for (int i = 0; i < 7; i++) step(1'b0, 4'b0011, 4'(i), 4'b0001);
    step(1'b0, 4'b0010, 4'b0011, 4'b0010);
    step(1'b0, 4'b0000, 4'b0010, 4'b0000);
    step(1'b0, 4'b0000, 4'b0000, 4'b0000);
`endif

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter that shares the team's 4-to-1 single-bit mux datapath among four requesters. It owns the mux select: it grants one requester at a time, drives the 2-bit select from the current owner, and returns a registered copy of the selected input bit with a valid flag. It sits between the four requester blocks and the downstream consumer of the muxed bit.

## Interface
Parameters:
- HOLD_MAX, 8, maximum consecutive grant cycles for one owner while others wait; legal range 2..255. Used only when MUX4_ARB_TIMEOUT_EN is defined.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- req  input  4  request per requester; requester holds it high for as long as it wants the mux
- x  input  4  data bits; x[i] belongs to requester i
- grant  output  4  one-hot grant, all-zero when idle
- sel  output  2  mux select = index of current owner; 0 when idle
- busy  output  1  high when any grant is active
- y  output  1  registered x[sel]
- y_valid  output  1  y holds a valid sample for the owner of the previous cycle

## Operation
- States: IDLE (no owner), GRANT (one owner, index in sel).
- Priority pointer ptr (2 bits): search order ptr, ptr+1, ptr+2, ptr+3 modulo 4. On every new grant to index k, ptr <= k+1 (3 wraps to 0).
- IDLE: if req != 0, grant the first set bit in search order; go GRANT. Else stay.
- GRANT, owner k:
  - req[k] low: at the same edge, grant the first other set bit in search order from k+1; if none, go IDLE (grant=0, sel=0).
  - req[k] high: keep grant (subject to timeout, see Configuration).
- grant is always one-hot or zero; sel always matches the grant index; busy = |grant.
- Datapath: each edge, y <= x[sel] and y_valid <= busy. When idle, y <= 0.
- Requests arriving in the same cycle are resolved purely by ptr; no requester may be granted twice in a row while another is pending and the current owner has released.

## Timing
- Reset (rst high at an edge): state IDLE, ptr=0, hold counter=0, grant=0, sel=0, busy=0, y=0, y_valid=0. Reset mid-grant drops the grant on that edge regardless of req.
- Grant latency: req sampled at edge N -> grant/sel/busy valid after edge N (visible in cycle N+1).
- Handover: owner deasserts req before edge N -> new owner granted after edge N; zero idle cycles between owners.
- Data latency: y/y_valid lag grant/sel by exactly one cycle; y at cycle t+1 equals x[sel] at cycle t.
- Release to idle: last owner drops req before edge N -> grant=0 after N, y_valid=0 after N+1.

## Configuration
- Macro MUX4_ARB_TIMEOUT_EN.
- Defined: 8-bit hold counter cleared on every new grant, incremented each GRANT cycle the owner keeps req high. At the edge where counter = HOLD_MAX-1 and any other req bit is set, grant rotates to the next requester in search order from k+1 (owner's req ignored for that decision); counter clears. If no other request is pending, owner keeps the grant and counter saturates at HOLD_MAX-1.
- Not defined: no counter, HOLD_MAX ignored; owner keeps the grant until it drops req.

## Test plan
- Reset: rst high 2 cycles with req=4'b1111 -> grant=0, sel=0, busy=0, y=0, y_valid=0 throughout; after release, grant=4'b0001 one edge later.
- Round-robin: req=4'b1111, each owner drops req for one cycle after 3 cycles of grant and re-raises -> grant sequence 0001, 0010, 0100, 1000, 0001 with no idle gaps.
- Data path: owner 2 granted, x toggles 1,0,1 on consecutive cycles -> y shows 1,0,1 one cycle later with y_valid=1; x[0],x[1],x[3] changes have no effect.
- Idle/empty: single req[3] pulse of 4 cycles -> grant=1000 for 4 cycles, sel=3, then grant=0, sel=0; y_valid drops one cycle after busy.
- Timeout (MUX4_ARB_TIMEOUT_EN, HOLD_MAX=4): req[0] held high, req[1] rises while 0 owns -> owner 0 for exactly 4 cycles, then grant=0010; with req[1] absent, owner 0 holds indefinitely.
- Timeout disabled build, same stimulus -> owner 0 holds until req[0] drops, then grant=0010 the next edge.
